// File: rtl/cfa_raster_streamer_pkg.sv
// Shared definitions for the CFA raster streamer: default widths, pad value and
// the frame FSM state encoding.
`timescale 1ns/1ps
package cfa_raster_streamer_pkg;

    localparam int PIX_W_DEF     = 4;
    localparam int PAD_VALUE_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAD_TOP = 2'd1,
        ST_BODY    = 2'd2,
        ST_PAD_BOT = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfa_raster_streamer_wrap_counter.sv
// Up-counter that returns to zero after its terminal value; wrap flags the
// increment that performs the roll-over so it can gate a higher counter.
`timescale 1ns/1ps
module wrap_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = inc && (r_count == TERM);
    assign wrap   = w_wrap;
    assign count  = r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= w_wrap ? '0 : r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cfa_raster_streamer.sv
// Raster streamer for the nx2D window buffer: pulls Bayer pixels over valid/ready
// and emits a registered, pad-ringed frame with sof/eol/eof markers.
`timescale 1ns/1ps
module cfa_raster_streamer
    import cfa_raster_streamer_pkg::*;
#(
    parameter int               PIX_W     = PIX_W_DEF,
    parameter int               IMG_W     = 8,
    parameter int               IMG_H     = 8,
    parameter int               PAD       = 1,
    parameter logic [PIX_W-1:0] PAD_VALUE = PIX_W'(PAD_VALUE_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] src_data,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic             dst_ready,
    output logic [PIX_W-1:0] d_out,
    output logic             en_out,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             busy
);

    localparam int COLS = IMG_W + 2 * PAD;
    localparam int ROWS = IMG_H + 2 * PAD;
    localparam int CW   = cnt_w(COLS);
    localparam int RW   = cnt_w(ROWS);

    localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_ACT_LO    = CW'(PAD);
    localparam logic [CW-1:0] COL_ACT_HI    = CW'(IMG_W + PAD - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_TOP_LAST  = RW'(PAD - 1);
    localparam logic [RW-1:0] ROW_BODY_LAST = RW'(IMG_H + PAD - 1);

    state_t           r_state;
    logic             r_busy;
    logic [PIX_W-1:0] r_d;
    logic             r_en;
    logic             r_sof;
    logic             r_eol;
    logic             r_eof;

    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic             w_col_wrap;
    logic             w_row_wrap;
    logic             w_active;
    logic             w_adv;
    logic             w_clr;

    // Rows are implied by the state, so only the column needs testing for activity.
    assign w_active  = (r_state == ST_BODY) && (w_col >= COL_ACT_LO) && (w_col <= COL_ACT_HI);
    assign w_adv     = (r_state != ST_IDLE) && dst_ready && (!w_active || src_valid);
    assign w_clr     = (r_state == ST_IDLE);
    assign src_ready = w_active && dst_ready;

    wrap_counter #(.WIDTH(CW), .TERM(COL_LAST)) u_col_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_adv),
        .clr   (w_clr),
        .count (w_col),
        .wrap  (w_col_wrap)
    );

    wrap_counter #(.WIDTH(RW), .TERM(ROW_LAST)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_col_wrap),
        .clr   (w_clr),
        .count (w_row),
        .wrap  (w_row_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:    if (start) r_state <= ST_PAD_TOP;
                ST_PAD_TOP: if (w_col_wrap && (w_row == ROW_TOP_LAST)) r_state <= ST_BODY;
                ST_BODY:    if (w_col_wrap && (w_row == ROW_BODY_LAST)) r_state <= ST_PAD_BOT;
                ST_PAD_BOT: if (w_row_wrap) r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
            // A start taken in the eof cycle keeps busy asserted for the next frame.
            if ((r_state == ST_IDLE) && start) begin
                r_busy <= 1'b1;
            end else if (r_eof) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d   <= '0;
            r_en  <= 1'b0;
            r_sof <= 1'b0;
            r_eol <= 1'b0;
            r_eof <= 1'b0;
        end else begin
            r_en  <= w_adv;
            r_sof <= w_adv && (w_row == '0) && (w_col == '0);
            r_eol <= w_col_wrap;
            r_eof <= w_row_wrap;
            if (w_adv) begin
                r_d <= w_active ? src_data : PAD_VALUE;
            end
        end
    end

    assign d_out  = r_d;
    assign en_out = r_en;
    assign sof    = r_sof;
    assign eol    = r_eol;
    assign eof    = r_eof;
    assign busy   = r_busy;

endmodule

// File: tb/tb_cfa_raster_streamer.sv
// Directed bench for cfa_raster_streamer: 8x8/PAD=1 and 4x4/PAD=2 instances,
// checked against a small position model and hand-derived pixel values.
`timescale 1ns/1ps
module tb_cfa_raster_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       src_valid;
    logic       dst_ready;
    logic [3:0] src_data;
    logic       sel;

    logic       a_src_ready, a_en, a_sof, a_eol, a_eof, a_busy;
    logic [3:0] a_d;
    logic       b_src_ready, b_en, b_sof, b_eol, b_eof, b_busy;
    logic [3:0] b_d;
    logic       start_a, start_b;

    logic       src_ready, en_out, sof, eol, eof, busy;
    logic [3:0] d_out;

    always #5 clk = ~clk;

    assign start_a   = start & ~sel;
    assign start_b   = start & sel;
    assign src_ready = sel ? b_src_ready : a_src_ready;
    assign en_out    = sel ? b_en  : a_en;
    assign sof       = sel ? b_sof : a_sof;
    assign eol       = sel ? b_eol : a_eol;
    assign eof       = sel ? b_eof : a_eof;
    assign busy      = sel ? b_busy : a_busy;
    assign d_out     = sel ? b_d : a_d;

    cfa_raster_streamer #(.PIX_W(4), .IMG_W(8), .IMG_H(8), .PAD(1), .PAD_VALUE(4'd0)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (a_src_ready),
        .dst_ready (dst_ready),
        .d_out     (a_d),
        .en_out    (a_en),
        .sof       (a_sof),
        .eol       (a_eol),
        .eof       (a_eof),
        .busy      (a_busy)
    );

    cfa_raster_streamer #(.PIX_W(4), .IMG_W(4), .IMG_H(4), .PAD(2), .PAD_VALUE(4'd0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (b_src_ready),
        .dst_ready (dst_ready),
        .d_out     (b_d),
        .en_out    (b_en),
        .sof       (b_sof),
        .eol       (b_eol),
        .eof       (b_eof),
        .busy      (b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int img_w, pad, cw, chh, total;
    bit m_run;
    int m_k;
    bit m_exp_en;
    int src_idx;
    bit xfer;
    int cyc, first_cyc, last_cyc;
    int err_ready, err_en, err_mark;
    bit busy_s, eof_s;
    logic [6:0] pix_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_geom(input int w, input int h, input int p);
        img_w = w;
        pad   = p;
        cw    = w + 2 * p;
        chh   = h + 2 * p;
        total = cw * chh;
    endtask

    function automatic bit is_active(input int k);
        int r, c;
        r = k / cw;
        c = k % cw;
        return (r >= pad) && (r < chh - pad) && (c >= pad) && (c < cw - pad);
    endfunction

    // {d_out, sof, eol, eof} for padded-raster index k.
    function automatic logic [6:0] exp_pix(input int k);
        int r, c;
        logic [3:0] d;
        r = k / cw;
        c = k % cw;
        d = is_active(k) ? 4'(((r - pad) * img_w + (c - pad) + 1) % 16) : 4'd0;
        return {d, k == 0, c == cw - 1, k == total - 1};
    endfunction

    task automatic reset_model();
        m_run     = 1'b0;
        m_k       = 0;
        src_idx   = 0;
        xfer      = 1'b0;
        err_ready = 0;
        err_en    = 0;
        err_mark  = 0;
        eof_s     = 1'b0;
        pix_q.delete();
    endtask

    // Inputs are set by the caller before step; outputs are sampled 1ns after the edge.
    task automatic step();
        bit exp_ready;
        src_data = 4'((src_idx + 1) % 16);
        #1;
        exp_ready = m_run && dst_ready && is_active(m_k);
        if (src_ready !== exp_ready) err_ready++;
        xfer     = src_valid && src_ready;
        m_exp_en = 1'b0;
        if (m_run) begin
            if (dst_ready && (!is_active(m_k) || src_valid)) begin
                m_exp_en = 1'b1;
                m_k++;
                if (m_k == total) m_run = 1'b0;
            end
        end else if (start) begin
            m_run = 1'b1;
            m_k   = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (xfer) src_idx++;
        if (en_out !== m_exp_en) err_en++;
        if (en_out === 1'b1) begin
            if (pix_q.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            pix_q.push_back({d_out, sof, eol, eof});
        end else if ((sof | eol | eof) !== 1'b0) begin
            err_mark++;
        end
        busy_s = busy;
        eof_s  = en_out && eof;
    endtask

    task automatic start_frame();
        start     = 1'b1;
        src_valid = 1'b1;
        dst_ready = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    // mode 0: plain, 1: src_valid toggles, 2: 5-cycle dst stall at position 34, 3: start at pixel 50
    task automatic run_frame(input string tag, input int mode, input int budget);
        int  n     = 0;
        bit  tog   = 1'b0;
        int  stall = 0;
        while (!eof_s && n < budget) begin
            src_valid = (mode == 1) ? tog : 1'b1;
            tog       = ~tog;
            dst_ready = 1'b1;
            if (mode == 2 && m_k == 34 && stall < 5) begin
                dst_ready = 1'b0;
                stall++;
            end
            start = (mode == 3) && (pix_q.size() == 50);
            step();
            n++;
        end
        start = 1'b0;
        check({tag, "_eof_reached"}, 32'(eof_s), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, pix_q.size(), total);
        check({tag, "_src_ready"}, err_ready, 0);
        check({tag, "_en_timing"}, err_en, 0);
        check({tag, "_markers_idle"}, err_mark, 0);
        for (int i = 0; i < pix_q.size() && i < total; i++) begin
            check($sformatf("%s_px%0d", tag, i), 32'(pix_q[i]), 32'(exp_pix(i)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, 32'(en_out), 0);
        check({tag, "_d"}, 32'(d_out), 0);
        check({tag, "_marks"}, {29'd0, sof, eol, eof}, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_src_ready"}, 32'(src_ready), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        src_data  = 4'd0;
        sel       = 1'b0;
        cyc       = 0;
        first_cyc = 0;
        last_cyc  = 0;
        set_geom(8, 8, 1);
        reset_model();
        #12;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Scenario 1: single frame
        reset_model();
        start     = 1'b1;
        src_valid = 1'b1;
        dst_ready = 1'b1;
        step();
        start = 1'b0;
        check("s1_busy_set", 32'(busy_s), 1);
        check("s1_no_en_first", 32'(en_out), 0);
        step();
        check("s1_first_pixel", pix_q.size(), 1);
        check("s1_first_sof", 32'(sof), 1);
        run_frame("s1", 0, 400);
        check("s1_busy_at_eof", 32'(busy_s), 1);
        check("s1_span", last_cyc - first_cyc + 1, 100);
        if (pix_q.size() > 11) check("s1_px11_first_src", 32'(pix_q[11][6:3]), 1);
        check_frame("s1");
        step();
        check("s1_busy_fall", 32'(busy_s), 0);

        // Scenario 2: source bubbles
        reset_model();
        start_frame();
        run_frame("s2", 1, 400);
        check("s2_has_gaps", 32'(last_cyc - first_cyc + 1 > 100), 1);
        check_frame("s2");
        step();

        // Scenario 3: backpressure at r=3, c=4
        reset_model();
        start_frame();
        run_frame("s3", 2, 400);
        check("s3_span", last_cyc - first_cyc + 1, 105);
        check_frame("s3");
        step();

        // Scenario 4: reset mid-frame after pixel 37
        reset_model();
        start_frame();
        for (int n = 0; n < 200 && pix_q.size() < 37; n++) step();
        check("s4_reached_37", pix_q.size(), 37);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s4_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        for (int n = 0; n < 5; n++) step();
        check("s4_quiet", pix_q.size(), 0);
        check("s4_quiet_timing", err_en, 0);
        start_frame();
        run_frame("s4", 0, 400);
        check_frame("s4");

        // Scenario 5: start while busy, then start the cycle after eof
        step();
        reset_model();
        start_frame();
        run_frame("s5a", 3, 400);
        check_frame("s5a");
        step();
        check("s5_busy_clear", 32'(busy_s), 0);
        reset_model();
        start = 1'b1;
        step();
        start = 1'b0;
        check("s5_lat1_no_en", 32'(en_out), 0);
        step();
        check("s5_lat2_sof", {30'd0, en_out, sof}, 32'd3);
        run_frame("s5b", 0, 400);
        check_frame("s5b");
        step();

        // Scenario 6: PAD=2 on a 4x4 image
        sel = 1'b1;
        set_geom(4, 4, 2);
        reset_model();
        step();
        start_frame();
        run_frame("s6", 0, 400);
        check_frame("s6");
        step();
        check("s6_busy_fall", 32'(busy_s), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cfa_raster_streamer.md
Name: cfa_raster_streamer

Overview:
- Transmit side of the CFA pixel-stream interface that feeds the nx2D window buffer (`d_in` plus `en` per pixel).
- Pulls raw Bayer pixels from an upstream frame reader over a valid/ready handshake.
- Emits one registered raster stream with a constant pad ring (PAD pixels per side), so the downstream 3x3 window is border-correct.
- Generates start-of-frame, end-of-line and end-of-frame markers for the CFA pipeline.

Parameters:
- PIX_W, 4, bits per pixel; matches window buffer `d_in` width.
- IMG_W, 8, active pixels per line.
- IMG_H, 8, active lines per frame.
- PAD, 1, pad pixels added on each side (top/bottom/left/right); legal values 1 or 2.
- PAD_VALUE, 0, constant emitted for pad pixels.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- src_data  in  PIX_W  active pixel from upstream.
- src_valid  in  1  src_data valid.
- src_ready  out  1  streamer accepts src_data this cycle.
- dst_ready  in  1  downstream may accept a pixel next cycle.
- d_out  out  PIX_W  registered pixel to the window buffer.
- en_out  out  1  d_out valid; drives the buffer `en`.
- sof  out  1  high with the first pixel of a frame.
- eol  out  1  high with the last pixel of each padded line.
- eof  out  1  high with the last pixel of the frame.
- busy  out  1  high from accepted start until the eof pixel is emitted.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - d_out=0, en_out=0, sof=0, eol=0, eof=0, busy=0, src_ready=0.
  - State returns to IDLE; row and col counters clear to 0.
  - No partial frame resumes after reset is released.
- Padded frame geometry:
  - Row counter r runs 0..IMG_H+2*PAD-1; column counter c runs 0..IMG_W+2*PAD-1.
  - (r,c) is an active position iff PAD<=r<IMG_H+PAD and PAD<=c<IMG_W+PAD; every other position is pad.
- FSM states: IDLE, PAD_TOP, BODY, PAD_BOT.
  - IDLE -> PAD_TOP on start; busy is set the next cycle.
  - PAD_TOP -> BODY after the last pixel of row PAD-1.
  - BODY -> PAD_BOT after the last pixel of row IMG_H+PAD-1.
  - PAD_BOT -> IDLE after the last pixel of the final row.
  - start outside IDLE is ignored.
- Position advance:
  - Pad position: a pixel is emitted and the position advances on any cycle with dst_ready=1.
  - Active position: src_ready = dst_ready, and only in BODY at an active column. The position advances only on a transfer (src_valid & src_ready).
  - src_ready=0 at all pad positions and outside BODY.
  - Column wraps to 0 and the row increments at the end of each line.
- Output register, latency 1:
  - When a position advances in cycle N, in cycle N+1: en_out=1, d_out = src_data (active) or PAD_VALUE (pad).
  - Otherwise en_out=0 and d_out holds its value.
  - First pixel: start sampled in cycle N, dst_ready=1 -> en_out=1 at N+2 (PAD_TOP entered at N+1).
- Markers: sof, eol and eof are registered alongside d_out and valid only when en_out=1. They are 0 whenever en_out=0.
- Pixel count: each frame emits exactly (IMG_W+2*PAD)*(IMG_H+2*PAD) pixels with en_out=1.
- busy timing: clears in the cycle after eof; start may be accepted in that same cycle.
- Stalls:
  - dst_ready=0 freezes counters and state and produces no emission.
  - src_valid=0 at an active position produces a bubble (en_out=0).
  - Both may last any number of cycles with no data loss.
- Simultaneous events:
  - rst dominates everything.
  - start together with dst_ready=0 is still accepted (IDLE->PAD_TOP); emission waits for dst_ready.

Decomposition:
- Shared include file cfa_defs: PIX_W default, FSM state encodings (IDLE=0, PAD_TOP=1, BODY=2, PAD_BOT=3), PAD_VALUE default.
- One sub-module, wrap_counter:
  - Parameterised width and terminal value; inputs inc and clr; outputs count and wrap.
  - Instantiated twice, for column and row; the column wrap gates the row increment.

Test Plan:
- Reset + single frame: IMG_W=IMG_H=8, PAD=1, src_valid=1 always, src_data=1..64 mod 16, dst_ready=1, start pulse.
  - Expect 100 en_out pulses in 100 consecutive cycles.
  - Pixel 0 = 0 with sof=1; pixels 0-9 = 0.
  - Pixel 11 = first src value; eol on pixels 9, 19, ..., 99; eof on pixel 99; busy falls the next cycle.
- Source bubbles: src_valid toggles 1,0,1,0 during BODY.
  - Expect one en_out gap per low cycle and the pixel sequence identical to scenario 1.
  - src_ready=0 on columns 0 and 9.
- Backpressure: hold dst_ready=0 for 5 cycles at r=3, c=4.
  - Expect en_out=0 and counters frozen for those cycles.
  - Output resumes with the same pixel; total remains 100.
- Reset mid-frame: assert rst at pixel 37, deassert 2 cycles later.
  - All outputs are 0 immediately (asynchronously).
  - No en_out until a new start; a new frame then restarts at sof with pad value 0.
- Start handling:
  - start while busy: no effect, frame count unchanged.
  - start in the cycle after eof: the next frame's sof appears 2 cycles later.
- PAD=2, IMG_W=4, IMG_H=4: expect 64 pixels.
  - Active pixels appear at rows 2-5, columns 2-5 only.
  - eol every 8 pixels.
